div_seq: RTL

Multi-cycle sequencer for 32-bit signed/unsigned division, one quotient bit per cycle, used by the execute stage for DIV/DIVU. The execute stage raises `start_i` and holds its stall request until `ready_o`. The result is written to HI/LO as {remainder, quotient}. The block owns a single shared 33-bit subtractor and walks it through 32 restoring iterations, then applies a sign correction.

---
 rtl/div_seq_pkg.sv | 19 +
 rtl/div_step.sv | 27 ++
 rtl/div_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: state encodings, handshake
// levels and the iteration count.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int unsigned DivIterations = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// upper half of the work register and shift in one quotient bit.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W:0] wr_i,
  input  logic [DATA_W-1:0] div_i,
  output logic [2*DATA_W:0] wr_o
);

  logic [DATA_W:0] diff;
  // The MSB is shifted out on every step and never feeds the subtractor.
  logic            unused_msb;

  assign unused_msb = wr_i[2*DATA_W];

  // Trial subtraction; diff[DATA_W] set means the partial remainder was too small.
  always_comb begin
    diff = {1'b0, wr_i[2*DATA_W-1:DATA_W]} - {1'b0, div_i};
    if (diff[DATA_W]) begin
      wr_o = {wr_i[2*DATA_W-1:0], 1'b0};
    end else begin
      wr_o = {diff[DATA_W-1:0], wr_i[DATA_W-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU. One quotient bit per
// cycle through a shared subtractor, then a sign correction.
// result_o = {remainder, quotient}.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DivIterations
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  div_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [2*DATA_W:0] wr_q;
  logic [2*DATA_W:0] wr_step;
  logic [DATA_W-1:0] div_q;
  logic              signed_q;
  logic              sign1_q;
  logic              sign2_q;
  logic [DATA_W-1:0] op1_abs;
  logic [DATA_W-1:0] op2_abs;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;

  div_step #(
    .DATA_W(DATA_W)
  ) u_div_step (
    .wr_i (wr_q),
    .div_i(div_q),
    .wr_o (wr_step)
  );

  // Operand magnitudes at issue and sign-corrected results at completion.
  always_comb begin
    op1_abs  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_abs  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? -wr_q[DATA_W-1:0] : wr_q[DATA_W-1:0];
    rem_fix  = (signed_q && sign1_q) ? -wr_q[2*DATA_W:DATA_W+1] : wr_q[2*DATA_W:DATA_W+1];
  end

  // Control FSM with registered result and ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      wr_q     <= '0;
      div_q    <= '0;
      signed_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            signed_q <= signed_div_i;
            sign1_q  <= opdata1_i[DATA_W-1];
            sign2_q  <= opdata2_i[DATA_W-1];
            div_q    <= op2_abs;
            cnt_q    <= '0;
            wr_q     <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
            state_q  <= (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state_q  <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else begin
            state_q  <= DivEnd;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (cnt_q != CntW'(DATA_W)) begin
            wr_q  <= wr_step;
            cnt_q <= cnt_q + CntW'(1);
          end else begin
            state_q  <= DivEnd;
            cnt_q    <= '0;
            result_o <= {rem_fix, quot_fix};
            ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          // Annul is deliberately ignored here; the result is already committed.
          if (start_i == DivStop) begin
            state_q  <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

endmodule
